// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the data-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

package dmem_port_arbiter_pkg;

    localparam int ADDR_LEN = `ADDR_LEN;
    localparam int DATA_LEN = `DATA_LEN;

    localparam int HIGH_WATER_DEF   = 24;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating counter with increment/clear; sat flags count == LIMIT.
// Latency: count updates one cycle after inc/clear; sat is combinational on count.
// Backpressure: none; clear has priority over increment, increment stops at LIMIT.
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    assign sat = (count == LIMIT_V);

    // Clear wins over increment; increment holds once the limit is reached.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between LSU loads and store-buffer drains.
// Latency: grant to mem_req_o is 1 cycle; ld_valid_o/st_ack_o pulse 1 cycle after mem_ack_i.
// Backpressure: loads win unless the store buffer is at HIGH_WATER or stores have starved; optional macro DMEM_ARB_SB_BYPASS_EN.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_LEN,
    parameter int DATA_W       = DATA_LEN,
    parameter int SB_CNT_W     = 5,
    parameter int HIGH_WATER   = HIGH_WATER_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int STARVE_W     = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                ld_req_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    output logic                ld_valid_o,
    output logic [DATA_W-1:0]   ld_rdata_o,
`ifdef DMEM_ARB_SB_BYPASS_EN
    input  logic                ld_sb_hit_i,
    input  logic [DATA_W-1:0]   ld_sb_data_i,
`endif
    input  logic                st_req_i,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_wdata_i,
    input  logic [SB_CNT_W-1:0] sb_count_i,
    output logic                st_ack_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    // One extra bit so a HIGH_WATER beyond the counter range simply never fires.
    localparam logic [SB_CNT_W:0] HIGH_WATER_X = (SB_CNT_W + 1)'(HIGH_WATER);

    arb_state_e           state;
    logic                 kill;
    logic                 eff_ld;
    logic                 sb_high;
    logic                 starve_sat;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 force_st;
    logic                 grant_st;
    logic                 grant_ld;
    logic                 bypass;
    logic [DATA_W-1:0]    bypass_data;
    logic                 starve_inc;
    logic                 starve_clr;

    assign eff_ld   = ld_req_i && !flush_i;
    assign sb_high  = ({1'b0, sb_count_i} >= HIGH_WATER_X);
    assign force_st = st_req_i && (sb_high || starve_sat);
    assign grant_st = force_st || (st_req_i && !eff_ld);

`ifdef DMEM_ARB_SB_BYPASS_EN
    // A forwarding hit answers the load directly unless a store is being forced.
    assign bypass      = eff_ld && ld_sb_hit_i && !force_st;
    assign bypass_data = ld_sb_data_i;
`else
    assign bypass      = 1'b0;
    assign bypass_data = '0;
`endif

    assign grant_ld   = eff_ld && !grant_st && !bypass;
    assign starve_inc = (state == IDLE) && grant_ld && st_req_i;
    assign starve_clr = (state == IDLE) && grant_st;

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_W)
    ) u_starve_ctr (
        .clk     (clk_i),
        .reset_n (reset_i),
        .inc     (starve_inc),
        .clear   (starve_clr),
        .count   (starve_cnt),
        .sat     (starve_sat)
    );

    // Arbitration FSM; every output is a register so the memory sees clean timing.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            kill        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ld_valid_o  <= 1'b0;
            ld_rdata_o  <= '0;
            st_ack_o    <= 1'b0;
        end else begin
            ld_valid_o <= 1'b0;
            st_ack_o   <= 1'b0;
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (grant_st) begin
                        state       <= ST_WAIT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= st_addr_i;
                        mem_wdata_o <= st_wdata_i;
                    end else if (bypass) begin
                        ld_valid_o <= 1'b1;
                        ld_rdata_o <= bypass_data;
                    end else if (grant_ld) begin
                        state      <= LD_WAIT;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= ld_addr_i;
                    end
                end
                LD_WAIT: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        kill      <= 1'b0;
                        // A flush seen earlier or on the ack cycle means the load is dead.
                        if (!kill && !flush_i) begin
                            ld_valid_o <= 1'b1;
                            ld_rdata_o <= mem_rdata_i;
                        end
                    end else if (flush_i) begin
                        kill <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Committed stores always complete; flush is deliberately ignored.
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        st_ack_o  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int AW = ADDR_LEN;
    localparam int DW = DATA_LEN;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          ld_req_i = 1'b0;
    logic [AW-1:0] ld_addr_i = '0;
    logic          ld_valid_o;
    logic [DW-1:0] ld_rdata_o;
    logic          st_req_i = 1'b0;
    logic [AW-1:0] st_addr_i = '0;
    logic [DW-1:0] st_wdata_i = '0;
    logic [4:0]    sb_count_i = '0;
    logic          st_ack_o;
    logic          flush_i = 1'b0;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
`ifdef DMEM_ARB_SB_BYPASS_EN
    logic          ld_sb_hit_i = 1'b0;
    logic [DW-1:0] ld_sb_data_i = '0;
`endif

    dmem_port_arbiter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_valid_o  (ld_valid_o),
        .ld_rdata_o  (ld_rdata_o),
`ifdef DMEM_ARB_SB_BYPASS_EN
        .ld_sb_hit_i (ld_sb_hit_i),
        .ld_sb_data_i(ld_sb_data_i),
`endif
        .st_req_i    (st_req_i),
        .st_addr_i   (st_addr_i),
        .st_wdata_i  (st_wdata_i),
        .sb_count_i  (sb_count_i),
        .st_ack_o    (st_ack_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int compared = 0;
    int mismatched = 0;

    // memory model and event log state
    bit            mem_auto = 1'b1;
    int            mem_lat_fixed = 1;
    bit            rd_ovr_en = 1'b0;
    logic [DW-1:0] rd_ovr = '0;
    int            reqcyc = 0;
    int            cur_lat = 1;
    bit            prev_ack_ld, prev_ack_st;
    bit            req_seen = 1'b0;
    bit            gq[$];
    int            cnt_req, cnt_we, cnt_ldv, cnt_sta, cnt_sta_al;
    logic [DW-1:0] last_ldv_data;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;
    st_t sq[$];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h9E37_79B1;
        return DW'(p ^ 32'h1234_5678);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        gq.delete();
        cnt_req = 0; cnt_we = 0; cnt_ldv = 0; cnt_sta = 0; cnt_sta_al = 0;
        last_ldv_data = '0;
    endtask

    // One clock: advance, log observed events, then drive the memory for the next edge.
    task automatic step();
        logic pre_req, pre_we, pre_ack, pre_rst;
        pre_req = mem_req_o; pre_we = mem_we_o; pre_ack = mem_ack_i; pre_rst = reset_i;
        @(posedge clk_i);
        #1;
        prev_ack_ld = pre_rst && pre_req && pre_ack && !pre_we;
        prev_ack_st = pre_rst && pre_req && pre_ack && pre_we;
        if (mem_req_o && !req_seen) gq.push_back(mem_we_o);
        req_seen = mem_req_o;
        if (mem_req_o) cnt_req++;
        if (mem_req_o && mem_we_o) cnt_we++;
        if (ld_valid_o) begin cnt_ldv++; last_ldv_data = ld_rdata_o; end
        if (st_ack_o) begin cnt_sta++; if (prev_ack_st) cnt_sta_al++; end
        if (mem_auto) begin
            if (mem_req_o && reset_i) begin
                if (reqcyc == 0) cur_lat = (mem_lat_fixed != 0) ? mem_lat_fixed : int'($urandom_range(1, 3));
                reqcyc++;
                if (reqcyc >= cur_lat) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = rd_ovr_en ? rd_ovr : mem_fn(mem_addr_o);
                    reqcyc = 0;
                end else begin
                    mem_ack_i = 1'b0;
                end
            end else begin
                mem_ack_i = 1'b0;
                reqcyc = 0;
            end
        end
    endtask

    task automatic do_reset();
        ld_req_i = 1'b0; st_req_i = 1'b0; flush_i = 1'b0; sb_count_i = '0;
        reset_i = 1'b0;
        step(); step();
        reset_i = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({mem_req_o, mem_we_o, ld_valid_o, st_ack_o}), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'(0));
        chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'(0));
        chk({tag, "_rdata"}, 64'(ld_rdata_o), 64'(0));
    endtask

    bit            exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit            seen_ack, done, drain, s_idle, s_ld, s_st, exp_st, exp_ld;
    int            s_sb, mstarve, ld_grants, st_grants;
    logic [AW-1:0] s_la, s_sa, ld_out_addr;
    logic [DW-1:0] s_sd;

    initial begin
        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Single load, 3-cycle memory, fixed read data
        clear_logs();
        mem_lat_fixed = 3; rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
        ld_addr_i = 32'h40; ld_req_i = 1'b1;
        repeat (12) begin step(); if (ld_valid_o) ld_req_i = 1'b0; end
        chk("ld_req_cycles", 64'(cnt_req), 64'(3));
        chk("ld_we_cycles", 64'(cnt_we), 64'(0));
        chk("ld_valid_count", 64'(cnt_ldv), 64'(1));
        chk("ld_rdata", 64'(last_ldv_data), 64'(32'hDEAD_BEEF));
        rd_ovr_en = 1'b0;

        // Single store
        clear_logs();
        mem_lat_fixed = 2;
        st_addr_i = 32'h100; st_wdata_i = 32'h55; sb_count_i = 5'd1; st_req_i = 1'b1;
        step();
        chk("st_req", 64'(mem_req_o), 64'(1));
        chk("st_we", 64'(mem_we_o), 64'(1));
        chk("st_addr", 64'(mem_addr_o), 64'(32'h100));
        chk("st_wdata", 64'(mem_wdata_o), 64'(32'h55));
        repeat (10) begin step(); if (st_ack_o) st_req_i = 1'b0; end
        chk("st_ack_count", 64'(cnt_sta), 64'(1));
        chk("st_ack_after_ack", 64'(cnt_sta_al), 64'(1));

        // Both requesters held, low occupancy, 1-cycle memory: starvation sequence
        do_reset();
        clear_logs();
        mem_lat_fixed = 1;
        ld_addr_i = 32'h80; st_addr_i = 32'h300; st_wdata_i = 32'h99; sb_count_i = 5'd3;
        ld_req_i = 1'b1; st_req_i = 1'b1;
        for (int k = 0; k < 60 && gq.size() < 10; k++) step();
        chk("seq_len_reached", 64'(gq.size() >= 10), 64'(1));
        for (int k = 0; k < 10 && k < gq.size(); k++)
            chk($sformatf("seq_grant%0d", k), 64'(gq[k]), 64'(exp_seq[k]));
        ld_req_i = 1'b0; st_req_i = 1'b0;
        repeat (4) step();

        // High-water store beats a simultaneous load
        do_reset();
        clear_logs();
        st_addr_i = 32'h120; st_wdata_i = 32'h5A; sb_count_i = 5'd24;
        ld_addr_i = 32'h84; ld_req_i = 1'b1; st_req_i = 1'b1;
        step();
        chk("hw_first_we", 64'(mem_we_o), 64'(1));
        chk("hw_first_addr", 64'(mem_addr_o), 64'(32'h120));
        repeat (10) begin
            step();
            if (st_ack_o) st_req_i = 1'b0;
            if (ld_valid_o) ld_req_i = 1'b0;
        end
        chk("hw_grants", 64'(gq.size()), 64'(2));
        if (gq.size() >= 2) chk("hw_second_is_load", 64'(gq[1]), 64'(0));

        // Flush while waiting on a load, then a store
        clear_logs();
        mem_lat_fixed = 3; sb_count_i = 5'd0;
        ld_addr_i = 32'h44; ld_req_i = 1'b1;
        step();
        flush_i = 1'b1; ld_req_i = 1'b0;
        step();
        flush_i = 1'b0;
        repeat (6) step();
        chk("flush_no_valid", 64'(cnt_ldv), 64'(0));
        chk("flush_idle", 64'(mem_req_o), 64'(0));
        st_addr_i = 32'h200; st_wdata_i = 32'h77; st_req_i = 1'b1;
        step();
        chk("post_flush_st_we", 64'(mem_we_o), 64'(1));
        chk("post_flush_st_addr", 64'(mem_addr_o), 64'(32'h200));
        repeat (8) begin step(); if (st_ack_o) st_req_i = 1'b0; end
        chk("post_flush_st_ack", 64'(cnt_sta), 64'(1));

        // Flush on the same cycle as the memory ack
        clear_logs();
        mem_lat_fixed = 2; seen_ack = 1'b0;
        ld_addr_i = 32'h48; ld_req_i = 1'b1;
        for (int k = 0; k < 10 && !seen_ack; k++) begin step(); seen_ack = mem_ack_i; end
        chk("flush_ack_seen", 64'(seen_ack), 64'(1));
        flush_i = 1'b1; ld_req_i = 1'b0;
        step();
        flush_i = 1'b0;
        repeat (4) step();
        chk("flush_ack_no_valid", 64'(cnt_ldv), 64'(0));

        // Reset in the middle of a store; a late ack must be ignored
        clear_logs();
        mem_auto = 1'b0; mem_ack_i = 1'b0;
        st_addr_i = 32'h180; st_wdata_i = 32'hAB; st_req_i = 1'b1;
        step();
        chk("rst_st_granted", 64'(mem_req_o), 64'(1));
        step();
        reset_i = 1'b0;
        step();
        chk_all_zero("rst_mid");
        reset_i = 1'b1; mem_ack_i = 1'b1;
        step();
        chk("rst_late_ack_no_stack", 64'(st_ack_o), 64'(0));
        chk("rst_regrant_req", 64'(mem_req_o), 64'(1));
        chk("rst_regrant_addr", 64'(mem_addr_o), 64'(32'h180));
        mem_ack_i = 1'b0;
        step();
        chk("rst_still_waiting", 64'({mem_req_o, st_ack_o}), 64'(2'b10));
        clear_logs();
        mem_auto = 1'b1; mem_lat_fixed = 1;
        repeat (6) begin step(); if (st_ack_o) st_req_i = 1'b0; end
        chk("rst_regrant_ack", 64'(cnt_sta), 64'(1));

        // Randomized traffic against a transaction-level arbitration model
        do_reset();
        clear_logs();
        mem_lat_fixed = 0; mstarve = 0; ld_grants = 0; st_grants = 0;
        sq.delete(); done = 1'b0; ld_out_addr = '0;
        for (int i = 0; i < 4000; i++) begin
            drain = (i >= 3000);
            if (drain && sq.size() == 0 && !ld_req_i && !mem_req_o && !ld_valid_o && !st_ack_o) begin
                done = 1'b1;
                break;
            end
            s_idle = !mem_req_o; s_ld = ld_req_i; s_st = st_req_i; s_sb = int'(sb_count_i);
            s_la = ld_addr_i; s_sa = st_addr_i; s_sd = st_wdata_i;
            step();
            chk("rnd_ld_valid", 64'(ld_valid_o), 64'(prev_ack_ld));
            chk("rnd_st_ack", 64'(st_ack_o), 64'(prev_ack_st));
            if (ld_valid_o) chk("rnd_rdata", 64'(ld_rdata_o), 64'(mem_fn(ld_out_addr)));
            if (s_idle) begin
                exp_st = s_st && (s_sb >= 24 || mstarve >= 4 || !s_ld);
                exp_ld = !exp_st && s_ld;
                chk("rnd_grant", 64'(mem_req_o), 64'(exp_st || exp_ld));
                if (exp_st) begin
                    chk("rnd_st_we", 64'(mem_we_o), 64'(1));
                    chk("rnd_st_addr", 64'(mem_addr_o), 64'(s_sa));
                    chk("rnd_st_wdata", 64'(mem_wdata_o), 64'(s_sd));
                    mstarve = 0;
                    st_grants++;
                end else if (exp_ld) begin
                    chk("rnd_ld_we", 64'(mem_we_o), 64'(0));
                    chk("rnd_ld_addr", 64'(mem_addr_o), 64'(s_la));
                    ld_out_addr = s_la;
                    if (s_st && mstarve < 4) mstarve++;
                    ld_grants++;
                end
            end
            if (st_ack_o && sq.size() > 0) sq.delete(0);
            if (ld_valid_o) ld_req_i = 1'b0;
            if (!drain && !ld_req_i && $urandom_range(0, 2) == 0) begin
                ld_req_i = 1'b1;
                ld_addr_i = AW'($urandom);
            end
            if (!drain && sq.size() < 8 && $urandom_range(0, 3) == 0)
                sq.push_back('{a: AW'($urandom), d: DW'($urandom)});
            st_req_i = (sq.size() > 0);
            if (sq.size() > 0) begin st_addr_i = sq[0].a; st_wdata_i = sq[0].d; end
            sb_count_i = ($urandom_range(0, 7) == 0) ? 5'(24 + $urandom_range(0, 7))
                                                    : 5'($urandom_range(0, 23));
        end
        chk("rnd_drained", 64'(done), 64'(1));
        chk("rnd_load_returns", 64'(cnt_ldv), 64'(ld_grants));
        chk("rnd_store_acks", 64'(cnt_sta), 64'(st_grants));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
